// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared mode encoding, field limits and month table for the wall-clock core
package clk_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK    = 2'd0,
        MODE_TIMER    = 2'd1,
        MODE_ALARM    = 2'd2,
        MODE_SET_TIME = 2'd3
    } mode_t;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] HR24_MAX = 6'd23;
    localparam logic [5:0] HR12_MAX = 6'd12;

    localparam logic [4:0] MONTH_DAYS [0:11] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] month_len(input logic [3:0] month);
        logic [3:0] idx;
        idx = month - 4'd1;
        return MONTH_DAYS[idx];
    endfunction

endpackage

// File: rtl/clk_calendar.sv
// rtl/clk_calendar.sv - day/month/year counter advanced by the midnight carry
// CLK_LEAP_YEAR_EN: when defined, February of a Gregorian leap year has 29 days.
module clk_calendar
    import clk_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        day_inc,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [11:0] year
);

    logic [4:0] last_day;

`ifdef CLK_LEAP_YEAR_EN
    function automatic logic is_leap(input logic [11:0] y);
        return ((y[1:0] == 2'd0) && ((y % 12'd100) != 12'd0)) || ((y % 12'd400) == 12'd0);
    endfunction
`endif

    always_comb begin
        last_day = month_len(month);
`ifdef CLK_LEAP_YEAR_EN
        if (month == 4'd2 && is_leap(year)) begin
            last_day = 5'd29;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            day   <= 5'd1;
            month <= 4'd1;
            year  <= 12'd2000;
        end else if (day_inc) begin
            if (day == last_day) begin
                day <= 5'd1;
                if (month == 4'd12) begin
                    month <= 4'd1;
                    year  <= year + 12'd1;
                end else begin
                    month <= month + 4'd1;
                end
            end else begin
                day <= day + 5'd1;
            end
        end
    end

endmodule

// File: rtl/clock_with_mode_fsm.sv
// rtl/clock_with_mode_fsm.sv - wall clock with calendar, countdown timer, daily alarm and button mode FSM
// Leap-year handling inside clk_calendar is selected by CLK_LEAP_YEAR_EN.
module clock_with_mode_fsm
    import clk_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_btn,
    input  logic        add_hour,
    input  logic        add_minute,
    input  logic        set_timer_btn,
    input  logic        set_alarm_btn,
    input  logic        AM_mode,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [5:0]  hr,
    output logic        AM_PM,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [11:0] year,
    output logic        timer_buzzer,
    output logic        alarm_buzzer,
    output logic [5:0]  timer_min_left,
    output logic [5:0]  timer_sec_left
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic mode_prev, hour_prev, minute_prev, timer_prev, alarm_prev;
    logic mode_edge, hour_edge, minute_edge, timer_edge, alarm_edge;
    mode_t mode, mode_nxt;
    logic [5:0] hr24, hr12, sec_nxt, min_nxt, hr_nxt;
    logic man_min, man_hr, min_carry, hr_carry, day_inc;
    logic [5:0] preset, preset_nxt, tmr_min, tmr_min_nxt, tmr_sec, tmr_sec_nxt;
    logic running, running_nxt, timer_buzzer_nxt;
    logic [5:0] alarm_min, alarm_min_nxt, alarm_hr, alarm_hr_nxt;
    logic armed, armed_nxt;

    assign tick        = (presc == PRESC_LAST);
    assign mode_edge   = mode_btn & ~mode_prev;
    assign hour_edge   = add_hour & ~hour_prev;
    assign minute_edge = add_minute & ~minute_prev;
    assign timer_edge  = set_timer_btn & ~timer_prev;
    assign alarm_edge  = set_alarm_btn & ~alarm_prev;

    always_comb begin
        mode_nxt = mode;
        if (mode_edge) begin
            case (mode)
                MODE_CLOCK:    mode_nxt = MODE_TIMER;
                MODE_TIMER:    mode_nxt = MODE_ALARM;
                MODE_ALARM:    mode_nxt = MODE_SET_TIME;
                MODE_SET_TIME: mode_nxt = MODE_CLOCK;
            endcase
        end
    end

    // A manual set of a field swallows the tick carry into it, and with it any further carry.
    always_comb begin
        man_min   = (mode == MODE_SET_TIME) && minute_edge;
        man_hr    = (mode == MODE_SET_TIME) && hour_edge;
        min_carry = tick && (sec == SEC_MAX) && !man_min;
        hr_carry  = min_carry && (min == MIN_MAX) && !man_hr;
        day_inc   = hr_carry && (hr24 == HR24_MAX);
        sec_nxt   = tick ? inc_wrap(sec, SEC_MAX) : sec;
        min_nxt   = (man_min || min_carry) ? inc_wrap(min, MIN_MAX) : min;
        hr_nxt    = (man_hr || hr_carry) ? inc_wrap(hr24, HR24_MAX) : hr24;
    end

    always_comb begin
        preset_nxt       = preset;
        tmr_min_nxt      = tmr_min;
        tmr_sec_nxt      = tmr_sec;
        running_nxt      = running;
        timer_buzzer_nxt = timer_buzzer;
        if (mode == MODE_TIMER && minute_edge && !running) begin
            preset_nxt = inc_wrap(preset, MIN_MAX);
        end
        if (timer_edge) begin
            if (timer_buzzer) begin
                timer_buzzer_nxt = 1'b0;
                running_nxt      = 1'b0;
            end else if (running) begin
                running_nxt = 1'b0;
            end else if (preset != 6'd0) begin
                tmr_min_nxt = preset;
                tmr_sec_nxt = 6'd0;
                running_nxt = 1'b1;
            end
        end else if (running && tick) begin
            if (tmr_sec == 6'd0) begin
                tmr_sec_nxt = SEC_MAX;
                tmr_min_nxt = tmr_min - 6'd1;
            end else begin
                tmr_sec_nxt = tmr_sec - 6'd1;
            end
            if (tmr_min == 6'd0 && tmr_sec == 6'd1) begin
                running_nxt      = 1'b0;
                timer_buzzer_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        alarm_min_nxt = alarm_min;
        alarm_hr_nxt  = alarm_hr;
        if (mode == MODE_ALARM && minute_edge) alarm_min_nxt = inc_wrap(alarm_min, MIN_MAX);
        if (mode == MODE_ALARM && hour_edge)   alarm_hr_nxt  = inc_wrap(alarm_hr, HR24_MAX);
        armed_nxt = armed ^ alarm_edge;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc        <= '0;
            mode_prev    <= 1'b0;
            hour_prev    <= 1'b0;
            minute_prev  <= 1'b0;
            timer_prev   <= 1'b0;
            alarm_prev   <= 1'b0;
            mode         <= MODE_CLOCK;
            sec          <= 6'd0;
            min          <= 6'd0;
            hr24         <= 6'd0;
            preset       <= 6'd0;
            tmr_min      <= 6'd0;
            tmr_sec      <= 6'd0;
            running      <= 1'b0;
            timer_buzzer <= 1'b0;
            alarm_min    <= 6'd0;
            alarm_hr     <= 6'd0;
            armed        <= 1'b0;
            alarm_buzzer <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + 1'b1;
            mode_prev    <= mode_btn;
            hour_prev    <= add_hour;
            minute_prev  <= add_minute;
            timer_prev   <= set_timer_btn;
            alarm_prev   <= set_alarm_btn;
            mode         <= mode_nxt;
            sec          <= sec_nxt;
            min          <= min_nxt;
            hr24         <= hr_nxt;
            preset       <= preset_nxt;
            tmr_min      <= tmr_min_nxt;
            tmr_sec      <= tmr_sec_nxt;
            running      <= running_nxt;
            timer_buzzer <= timer_buzzer_nxt;
            alarm_min    <= alarm_min_nxt;
            alarm_hr     <= alarm_hr_nxt;
            armed        <= armed_nxt;
            // Compared against next-state time so the buzzer tracks the displayed minute exactly.
            alarm_buzzer <= armed_nxt && (hr_nxt == alarm_hr_nxt) && (min_nxt == alarm_min_nxt);
        end
    end

    clk_calendar u_calendar (
        .clk     (clk),
        .reset   (reset),
        .day_inc (day_inc),
        .day     (day),
        .month   (month),
        .year    (year)
    );

    always_comb begin
        if (hr24 == 6'd0)         hr12 = HR12_MAX;
        else if (hr24 > HR12_MAX) hr12 = hr24 - HR12_MAX;
        else                      hr12 = hr24;
    end

    assign hr             = AM_mode ? hr12 : hr24;
    assign AM_PM          = AM_mode && (hr24 >= HR12_MAX);
    assign timer_min_left = running ? tmr_min : preset;
    assign timer_sec_left = running ? tmr_sec : 6'd0;

endmodule

// File: tb/tb_clock_with_mode_fsm.sv
// tb/tb_clock_with_mode_fsm.sv - randomized and directed checks of the clock core against a behavioural model
module tb_clock_with_mode_fsm;

    localparam int TPS = 1;

    logic clk = 0, reset = 0;
    logic mode_btn = 0, add_hour = 0, add_minute = 0, set_timer_btn = 0, set_alarm_btn = 0;
    logic AM_mode = 1, cal_inc = 0;
    logic [5:0] sec, min, hr, timer_min_left, timer_sec_left;
    logic AM_PM, timer_buzzer, alarm_buzzer;
    logic [4:0] day, cal_day;
    logic [3:0] month, cal_month;
    logic [11:0] year, cal_year;

    clock_with_mode_fsm #(.TICKS_PER_SEC(TPS)) dut (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .add_hour(add_hour),
        .add_minute(add_minute), .set_timer_btn(set_timer_btn), .set_alarm_btn(set_alarm_btn),
        .AM_mode(AM_mode), .sec(sec), .min(min), .hr(hr), .AM_PM(AM_PM), .day(day),
        .month(month), .year(year), .timer_buzzer(timer_buzzer), .alarm_buzzer(alarm_buzzer),
        .timer_min_left(timer_min_left), .timer_sec_left(timer_sec_left)
    );

    clk_calendar cal (
        .clk(clk), .reset(reset), .day_inc(cal_inc),
        .day(cal_day), .month(cal_month), .year(cal_year)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integers, timer kept as seconds remaining.
    int m_sec, m_min, m_hr, m_day, m_mon, m_year, m_mode;
    int m_preset, m_trem, m_amin, m_ahr, m_pc;
    bit m_run, m_tbuz, m_arm, m_abuz;
    bit p_mode, p_hr, p_min, p_tmr, p_alm;
    int c_day, c_mon, c_year;

    function automatic int dim(int mo, int y);
        int t [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
`ifdef CLK_LEAP_YEAR_EN
        if (mo == 2 && ((y % 4 == 0 && y % 100 != 0) || y % 400 == 0)) return 29;
`endif
        return t[mo-1];
    endfunction

    task automatic adv_date(inout int d, inout int mo, inout int y);
        if (d == dim(mo, y)) begin
            d = 1;
            if (mo == 12) begin mo = 1; y = (y + 1) % 4096; end
            else mo = mo + 1;
        end else d = d + 1;
    endtask

    always @(posedge clk) begin : model
        bit e_mode, e_hr, e_min, e_tmr, e_alm, tick, man_m, man_h, ch, cd, run0;
        int mi, h;
        if (!reset) begin
            m_sec = 0; m_min = 0; m_hr = 0; m_day = 1; m_mon = 1; m_year = 2000; m_mode = 0;
            m_preset = 0; m_trem = 0; m_run = 0; m_tbuz = 0; m_amin = 0; m_ahr = 0;
            m_arm = 0; m_abuz = 0; m_pc = 0;
            {p_mode, p_hr, p_min, p_tmr, p_alm} = '0;
            c_day = 1; c_mon = 1; c_year = 2000;
        end else begin
            e_mode = mode_btn && !p_mode;      e_hr  = add_hour && !p_hr;
            e_min  = add_minute && !p_min;     e_tmr = set_timer_btn && !p_tmr;
            e_alm  = set_alarm_btn && !p_alm;
            tick = (m_pc == TPS - 1);
            m_pc = tick ? 0 : m_pc + 1;
            man_m = (m_mode == 3) && e_min;
            man_h = (m_mode == 3) && e_hr;
            ch = 0; cd = 0;
            if (man_m) mi = (m_min + 1) % 60;
            else if (tick && m_sec == 59) begin mi = (m_min + 1) % 60; ch = (m_min == 59); end
            else mi = m_min;
            if (man_h) h = (m_hr + 1) % 24;
            else if (ch) begin h = (m_hr + 1) % 24; cd = (m_hr == 23); end
            else h = m_hr;
            if (tick) m_sec = (m_sec + 1) % 60;
            m_min = mi; m_hr = h;
            if (cd) adv_date(m_day, m_mon, m_year);
            run0 = m_run;
            if (e_tmr) begin
                if (m_tbuz) begin m_tbuz = 0; m_run = 0; end
                else if (m_run) m_run = 0;
                else if (m_preset > 0) begin m_trem = m_preset * 60; m_run = 1; end
            end else if (m_run && tick) begin
                m_trem--;
                if (m_trem == 0) begin m_run = 0; m_tbuz = 1; end
            end
            if (m_mode == 1 && e_min && !run0) m_preset = (m_preset + 1) % 60;
            if (m_mode == 2 && e_min) m_amin = (m_amin + 1) % 60;
            if (m_mode == 2 && e_hr) m_ahr = (m_ahr + 1) % 24;
            if (e_alm) m_arm = !m_arm;
            if (e_mode) m_mode = (m_mode + 1) % 4;
            m_abuz = m_arm && (m_hr == m_ahr) && (m_min == m_amin);
            p_mode = mode_btn; p_hr = add_hour; p_min = add_minute;
            p_tmr = set_timer_btn; p_alm = set_alarm_btn;
            if (cal_inc) adv_date(c_day, c_mon, c_year);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sec", sec, m_sec);
            chk("min", min, m_min);
            chk("hr", hr, AM_mode ? ((m_hr % 12 == 0) ? 12 : m_hr % 12) : m_hr);
            chk("AM_PM", AM_PM, (AM_mode && m_hr >= 12) ? 1 : 0);
            chk("date", {day, month, year}, {m_day[4:0], m_mon[3:0], m_year[11:0]});
            chk("timer_buzzer", timer_buzzer, m_tbuz);
            chk("alarm_buzzer", alarm_buzzer, m_abuz);
            chk("timer_min_left", timer_min_left, m_run ? m_trem / 60 : m_preset);
            chk("timer_sec_left", timer_sec_left, m_run ? m_trem % 60 : 0);
            chk("cal_date", {cal_day, cal_month, cal_year}, {c_day[4:0], c_mon[3:0], c_year[11:0]});
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_btn(int b, logic v);
        case (b)
            0: mode_btn = v;
            1: add_hour = v;
            2: add_minute = v;
            3: set_timer_btn = v;
            default: set_alarm_btn = v;
        endcase
    endtask

    task automatic press(int b);
        set_btn(b, 1'b1);
        step(1);
        set_btn(b, 1'b0);
        step(1);
    endtask

    initial begin
        int cnt;
        bit ok;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1;
        chk("rst_hr12", hr, 12);
        chk("rst_ampm", AM_PM, 0);
        chk("rst_time", {min, sec}, 0);
        chk("rst_date", {day, month, year}, {5'd1, 4'd1, 12'd2000});
        chk("rst_buzzers", {timer_buzzer, alarm_buzzer}, 0);
        chk("rst_timer", {timer_min_left, timer_sec_left}, 0);
        reset = 1;
        step(61);
        chk("t61_hr", hr, 12);
        chk("t61_min_sec", {min, sec}, {6'd1, 6'd1});
        chk("t61_model", m_min * 60 + m_sec, 61);

        press(0);
        repeat (5) press(2);
        chk("preset5", timer_min_left, 5);
        set_timer_btn = 1;
        step(1);
        chk("load_5_00", {timer_min_left, timer_sec_left}, {6'd5, 6'd0});
        set_timer_btn = 0;
        step(1);
        chk("first_dec_4_59", {timer_min_left, timer_sec_left}, {6'd4, 6'd59});
        chk("model_trem", m_trem, 299);
        step(298);
        chk("at_0_01", {timer_buzzer, timer_min_left, timer_sec_left}, {1'b0, 6'd0, 6'd1});
        step(1);
        chk("expire_300", timer_buzzer, 1);
        chk("expire_idle_disp", timer_min_left, 5);
        press(3);
        chk("buzzer_ack", timer_buzzer, 0);

        press(0); press(0);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 30 && m_hr != 23; j++) press(1);
            for (int j = 0; j < 70 && m_min != 59; j++) press(2);
            if (m_hr == 23 && m_min == 59) break;
        end
        ok = 0;
        for (int j = 0; j < 130; j++) begin
            if (m_hr == 0 && m_min == 0 && m_day == 2) begin ok = 1; break; end
            step(1);
        end
        chk("midnight_reached", ok, 1);
        chk("midnight_date", {day, month, year}, {5'd2, 4'd1, 12'd2000});
        AM_mode = 0; #1;
        chk("midnight_24h", hr, 0);
        AM_mode = 1; #1;
        chk("midnight_12h", {hr, AM_PM}, {6'd12, 1'b0});

        press(0); press(0); press(0);
        press(2); press(2);
        press(4);
        ok = 0;
        for (int j = 0; j < 200; j++) begin
            if (m_min == 2) begin ok = 1; break; end
            step(1);
        end
        chk("alarm_minute_reached", ok, 1);
        chk("alarm_on_at_00", {alarm_buzzer, sec}, {1'b1, 6'd0});
        cnt = 0;
        for (int j = 0; j < 100; j++) begin
            if (!alarm_buzzer) break;
            cnt++;
            step(1);
        end
        chk("alarm_len", cnt, 60);
        press(2);
        step(10);
        chk("alarm_rematch", alarm_buzzer, 1);
        set_alarm_btn = 1;
        step(1);
        chk("alarm_disarm", alarm_buzzer, 0);
        set_alarm_btn = 0;
        step(1);

        press(0); press(0); press(0);
        press(3);
        step(20);
        chk("running_min", timer_min_left, 4);
        reset = 0;
        step(1);
        reset = 1;
        chk("rst_mid_timer", {timer_buzzer, timer_min_left, timer_sec_left}, 0);
        press(3);
        step(3);
        chk("preset0_nostart", {timer_min_left, timer_sec_left}, 0);
        press(0);
        add_minute = 1;
        step(6);
        add_minute = 0;
        step(1);
        chk("held_once", timer_min_left, 1);

        for (int i = 0; i < 3000; i++) begin
            mode_btn      = ($urandom_range(0, 15) == 0);
            add_hour      = ($urandom_range(0, 7) == 0);
            add_minute    = ($urandom_range(0, 5) == 0);
            set_timer_btn = ($urandom_range(0, 29) == 0);
            set_alarm_btn = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 63) == 0) AM_mode = ~AM_mode;
            step(1);
        end
        {mode_btn, add_hour, add_minute, set_timer_btn, set_alarm_btn} = '0;
        step(2);

        cal_inc = 1;
        ok = 0;
        for (int j = 0; j < 1600; j++) begin
            if (cal_day == 28 && cal_month == 2 && cal_year == 2004) begin ok = 1; break; end
            step(1);
        end
        chk("cal_reach_28_02_2004", ok, 1);
        step(1);
        cal_inc = 0;
`ifdef CLK_LEAP_YEAR_EN
        chk("leap_next_day", {cal_day, cal_month}, {5'd29, 4'd2});
`else
        chk("leap_next_day", {cal_day, cal_month}, {5'd1, 4'd3});
`endif
        step(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_with_mode_fsm.md
Name: clock_with_mode_fsm

Overview:
Digital wall-clock core. Keeps time of day (24 h internally, 12/24 h display) and a calendar date, plus a minute/second countdown timer and a daily alarm. A mode FSM, driven by single-press buttons, selects which register set the add_hour/add_minute buttons adjust. It sits between debounced front-panel buttons and the display/buzzer drivers.

Parameters:
TICKS_PER_SEC, 1, clk cycles per one-second tick. 1 means every clk edge is one second; must be >=1.

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-low reset (reset==0 at posedge resets)
mode_btn  in  1  cycles the mode FSM; rising edge acts
add_hour  in  1  +1 hour to the field selected by mode; rising edge acts
add_minute  in  1  +1 minute to the field selected by mode; rising edge acts
set_timer_btn  in  1  start, cancel or acknowledge the timer; rising edge acts
set_alarm_btn  in  1  toggle alarm armed; rising edge acts
AM_mode  in  1  1 = 12 h display, 0 = 24 h display
sec  out  6  seconds 0-59
min  out  6  minutes 0-59
hr  out  6  hour: 1-12 if AM_mode, else 0-23
AM_PM  out  1  1 = PM (hr24>=12) in 12 h display; 0 in 24 h display
day  out  5  1-31
month  out  4  1-12
year  out  12  0-4095, wraps to 0
timer_buzzer  out  1  countdown expired (latched)
alarm_buzzer  out  1  alarm sounding
timer_min_left  out  6  timer minutes remaining (or preset when idle)
timer_sec_left  out  6  timer seconds remaining

Behaviour:
- One clock domain. Reset is synchronous and active-low.
- Reset values: time 00:00:00 (hr=12, AM_PM=0 when AM_mode=1). Date 01/01/2000. Mode CLOCK. Timer preset 0, idle, timer_min_left/sec_left 0. Alarm 00:00, disarmed. Both buzzers 0. Edge registers 0.
- Buttons: each button registers its previous value. An action fires on the cycle where btn=1 and prev=0. A held button acts once.
- Tick: a prescaler counts 0..TICKS_PER_SEC-1. The tick fires when it wraps.
- Time/date carry on a tick:
  - sec 59->0 carries into min; min 59->0 carries into hr24; hr24 23->0 carries into day.
  - day wraps to 1 after the month length and carries into month; month 12->1 carries into year.
  - Month lengths: 31,28,31,30,31,30,31,31,30,31,30,31.
- Mode FSM (2-bit state): 0 CLOCK -> 1 TIMER -> 2 ALARM -> 3 SET_TIME -> 0, one step per mode_btn edge.
- add_minute / add_hour by mode:
  - CLOCK: both ignored.
  - TIMER: add_minute increments the timer preset minutes, wrapping 59->0. add_hour is ignored. Both are ignored while the timer is running.
  - ALARM: adjusts alarm minute (wraps 59->0) and alarm hour (wraps 23->0).
  - SET_TIME: adjusts clock min (59->0) and hr24 (23->0) with no carry. sec and date are unaffected. If a tick carry targets the same field in the same cycle, the manual increment wins and the carry is dropped.
- Timer (any mode), on set_timer_btn:
  - If timer_buzzer=1: clear the buzzer and go idle.
  - Else if running: cancel and go idle.
  - Else if preset>0: load preset:00 on the next edge and start running.
- Timer running: decrements once per tick, borrowing sec 0->59. On the tick that reaches 00:00, timer_buzzer=1 on that same edge and the timer stops. The buzzer stays latched until set_timer_btn or reset.
- Timer idle display: timer_min_left=preset, timer_sec_left=0.
- Alarm:
  - set_alarm_btn toggles armed.
  - alarm_buzzer = armed && hr24==alarm_hr && min==alarm_min, registered. It sounds for the full matching minute.
  - Disarming clears it on the next edge.
- Reset asserted mid-operation overrides every other action.

Optional Feature:
CLK_LEAP_YEAR_EN. Defined: February has 29 days when (year%4==0 && year%100!=0) || year%400==0. Undefined: February always has 28 days.

Decomposition:
Shared package clk_pkg:
- mode enum MODE_CLOCK/TIMER/ALARM/SET_TIME.
- Month-length constant array.
- Field maxima (59, 23, 12).

One natural sub-module: clk_calendar (day/month/year counter with carry-in from midnight, leap logic under CLK_LEAP_YEAR_EN). Button edge detection stays inline.

Test Plan:
- Reset low 2 cycles then high, AM_mode=1 -> 12:00:00 AM, 01/01/2000, buzzers 0. After 61 ticks -> 12:01:01 AM.
- mode_btn once, add_minute x5, set_timer_btn -> Tleft 05:00, then 04:59 after 1 tick. timer_buzzer=1 exactly 300 ticks after load. set_timer_btn clears it.
- mode_btn x3 (SET_TIME), add_hour x23, add_minute x59, run 60 ticks -> rollover to 00:00, date 02/01/2000. AM_mode=0 shows hr=0; AM_mode=1 shows 12 AM.
- ALARM mode: set 00:02, arm. At 00:02:00 -> alarm_buzzer=1 for 60 ticks. set_alarm_btn mid-minute -> 0 next edge.
- Set date to 28/02/2004 23:59:59, one tick -> 29/02/2004 with CLK_LEAP_YEAR_EN, 01/03/2004 without.
- set_timer_btn with preset 0 -> no start. Held add_minute -> single increment. Reset mid-countdown -> timer idle 00:00, buzzer 0.
